cache_nway_wb: RTL and testbench



---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_nway_wb_if.sv | 18 +
 rtl/cache_lru_age.sv | 31 +++
 rtl/cache_nway_wb.sv | 145 ++++++++++++++
 tb/tb_cache_nway_wb.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, bus widths and geometry helpers for the n-way cache
package cache_pkg;
    typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;
    localparam int LINE_W  = 128;
    localparam int WORD_W  = 32;
    localparam int PADDR_W = 30;
    localparam int MADDR_W = 28;
    function automatic int index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction
    function automatic int tag_w(input int num_sets);
        return MADDR_W - $clog2(num_sets);
    endfunction
    function automatic int way_w(input int num_ways);
        return num_ways > 1 ? $clog2(num_ways) : 1;
    endfunction
endpackage

// File: rtl/cache_nway_wb_if.sv
// cache_nway_wb_if: processor word bus and line memory bus seen by the cache
interface cache_nway_wb_if;
    import cache_pkg::*;
    logic               proc_read, proc_write, proc_stall;
    logic [PADDR_W-1:0] proc_addr;
    logic [WORD_W-1:0]  proc_wdata, proc_rdata;
    logic               mem_read, mem_write, mem_ready;
    logic [MADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata, mem_rdata;
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_lru_age.sv
// cache_lru_age: per-set true-LRU ages and victim choice (lowest invalid way, else oldest)
module cache_lru_age import cache_pkg::*; #(
    parameter int NUM_WAYS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       access_en,
    input  logic [way_w(NUM_WAYS)-1:0] access_way,
    input  logic [NUM_WAYS-1:0]        valid,
    output logic [way_w(NUM_WAYS)-1:0] victim_way
);
    localparam int AW = way_w(NUM_WAYS);
    if (NUM_WAYS == 1) begin : g_one
        assign victim_way = '0;
    end else begin : g_age
        logic [AW-1:0] age [NUM_WAYS];
        // accessed way becomes youngest; only ways younger than it grow older, so ages stay a permutation
        always_ff @(posedge clk or posedge rst) begin
            if (rst) for (int w = 0; w < NUM_WAYS; w++) age[w] <= AW'(w);
            else if (access_en)
                for (int w = 0; w < NUM_WAYS; w++)
                    age[w] <= (w == int'(access_way)) ? '0 : (age[w] < age[access_way]) ? age[w] + 1'b1 : age[w];
        end
        // descending scans so the lowest index wins; invalid ways override the oldest way
        always_comb begin
            victim_way = '0;
            for (int w = NUM_WAYS - 1; w >= 0; w--) if (age[w] == AW'(NUM_WAYS - 1)) victim_way = AW'(w);
            for (int w = NUM_WAYS - 1; w >= 0; w--) if (!valid[w]) victim_way = AW'(w);
        end
    end
endmodule

// File: rtl/cache_nway_wb.sv
// cache_nway_wb: N-way set-associative write-back, write-allocate cache, word bus to 128-bit line memory.
// Define CACHE_PERF_CNT_EN to add saturating perf_hit/perf_miss/perf_wb counters.
module cache_nway_wb import cache_pkg::*; #(
    parameter int NUM_SETS  = 4,
    parameter int NUM_WAYS  = 2,
    parameter int READ_ONLY = 0
) (
    input logic clk,
    input logic proc_reset,
    cache_nway_wb_if.slave bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss,
    output logic [31:0] perf_wb
`endif
);
    localparam int IW = index_w(NUM_SETS);
    localparam int TW = tag_w(NUM_SETS);
    localparam int AW = way_w(NUM_WAYS);

    state_t            state;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TW-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [AW-1:0]     victim_all [NUM_SETS];
    logic [AW-1:0]     way_q, hit_way, victim, acc_way;
    logic [IW-1:0]     index;
    logic [TW-1:0]     tag;
    logic [1:0]        offset;
    logic              wr, req, hit, hit_ok, fill_done, acc_en;
    logic [LINE_W-1:0] hit_line;

    assign {tag, index, offset} = bus.proc_addr;
    assign wr        = bus.proc_write && READ_ONLY == 0;
    assign req       = bus.proc_read || wr;
    assign hit_ok    = state == IDLE && req && hit;
    assign fill_done = state == ALLOCATE && bus.mem_ready;
    assign acc_en    = hit_ok || fill_done;
    assign acc_way   = fill_done ? way_q : hit_way;
    assign victim    = victim_all[index];
    assign hit_line  = data_q[index][hit_way];
    assign bus.proc_stall = state != IDLE || (req && !hit);
    assign bus.proc_rdata = (state == IDLE && hit) ? hit_line[{offset, 5'd0} +: WORD_W] : '0;

    // parallel tag compare across every way of the addressed set
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
            if (valid_q[index][w] && tag_q[index][w] == tag) begin
                hit = 1'b1;
                hit_way = AW'(w);
            end
    end

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        cache_lru_age #(.NUM_WAYS(NUM_WAYS)) u_age (
            .clk        (clk),
            .rst        (proc_reset),
            .access_en  (acc_en && index == IW'(s)),
            .access_way (acc_way),
            .valid      (valid_q[s]),
            .victim_way (victim_all[s])
        );
    end

    // controller: dirty marking on write hits, miss decision, write-back of a dirty victim, line fetch
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            way_q         <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (state)
                IDLE:
                    if (hit_ok && wr) dirty_q[index][hit_way] <= 1'b1;
                    else if (req && !hit) begin
                        way_q <= victim;
                        if (READ_ONLY == 0 && valid_q[index][victim] && dirty_q[index][victim]) begin
                            bus.mem_addr  <= {tag_q[index][victim], index};
                            bus.mem_wdata <= data_q[index][victim];
                            bus.mem_write <= 1'b1;
                            state         <= WRITE_BACK;
                        end else begin
                            bus.mem_addr <= bus.proc_addr[PADDR_W-1:2];
                            bus.mem_read <= 1'b1;
                            state        <= ALLOCATE;
                        end
                    end
                WRITE_BACK:
                    if (bus.mem_ready) begin
                        bus.mem_write         <= 1'b0;
                        bus.mem_read          <= 1'b1;
                        bus.mem_addr          <= bus.proc_addr[PADDR_W-1:2];
                        dirty_q[index][way_q] <= 1'b0;
                        state                 <= ALLOCATE;
                    end
                ALLOCATE:
                    if (bus.mem_ready) begin
                        bus.mem_read          <= 1'b0;
                        valid_q[index][way_q] <= 1'b1;
                        dirty_q[index][way_q] <= 1'b0;
                        state                 <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end

    // line storage: write hits merge one word, fills replace tag and whole line
    always_ff @(posedge clk) begin
        if (hit_ok && wr) data_q[index][hit_way][{offset, 5'd0} +: WORD_W] <= bus.proc_wdata;
        if (fill_done) begin
            data_q[index][way_q] <= bus.mem_rdata;
            tag_q[index][way_q]  <= tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic fill_q;
    // saturating event counters; the re-access hit right after a fill is not a real hit
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            fill_q    <= 1'b0;
            perf_hit  <= '0;
            perf_miss <= '0;
            perf_wb   <= '0;
        end else begin
            fill_q <= fill_done;
            if (hit_ok && !fill_q && perf_hit != '1) perf_hit <= perf_hit + 1'b1;
            if (state == IDLE && req && !hit && perf_miss != '1) perf_miss <= perf_miss + 1'b1;
            if (state == WRITE_BACK && bus.mem_ready && perf_wb != '1) perf_wb <= perf_wb + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_nway_wb.sv
// tb_cache_nway_wb: directed checks of cache_nway_wb in 2-way, 4-way and read-only builds
module tb_cache_nway_wb;
    logic         clk = 1'b0, rst = 1'b0;
    logic         rd = 1'b0, wr = 1'b0, mready = 1'b0;
    logic [29:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [127:0] mrdata = '0;
    logic [1:0]   sel = 2'd0;
    int           n_vec = 0, n_err = 0;
    logic [2:0]   stall_v, mrd_v, mwr_v;
    logic [31:0]  rdata_v [3];
    logic [27:0]  maddr_v [3];
    logic [127:0] mwdata_v [3];
    logic         stall, mrd, mwr;
    logic [31:0]  rdata;
    logic [27:0]  maddr;
    logic [127:0] mwdata;

    localparam logic [127:0] LINE_A = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};

    always #5 clk = ~clk;

    cache_nway_wb_if b [3] ();

    for (genvar i = 0; i < 3; i++) begin : g_bus
        assign b[i].proc_read  = rd && sel == i;
        assign b[i].proc_write = wr && sel == i;
        assign b[i].proc_addr  = addr;
        assign b[i].proc_wdata = wdata;
        assign b[i].mem_rdata  = mrdata;
        assign b[i].mem_ready  = mready && sel == i;
        assign stall_v[i]  = b[i].proc_stall;
        assign mrd_v[i]    = b[i].mem_read;
        assign mwr_v[i]    = b[i].mem_write;
        assign rdata_v[i]  = b[i].proc_rdata;
        assign maddr_v[i]  = b[i].mem_addr;
        assign mwdata_v[i] = b[i].mem_wdata;
    end

    assign stall  = stall_v[sel];
    assign mrd    = mrd_v[sel];
    assign mwr    = mwr_v[sel];
    assign rdata  = rdata_v[sel];
    assign maddr  = maddr_v[sel];
    assign mwdata = mwdata_v[sel];

    cache_nway_wb #(.NUM_SETS(4), .NUM_WAYS(2), .READ_ONLY(0)) u_2way (.clk(clk), .proc_reset(rst), .bus(b[0]));
    cache_nway_wb #(.NUM_SETS(4), .NUM_WAYS(4), .READ_ONLY(0)) u_4way (.clk(clk), .proc_reset(rst), .bus(b[1]));
    cache_nway_wb #(.NUM_SETS(4), .NUM_WAYS(2), .READ_ONLY(1)) u_ro   (.clk(clk), .proc_reset(rst), .bus(b[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
        rd = r;
        wr = w;
        addr = a;
        wdata = d;
        #1;
    endtask

    task automatic reset_dut();
        rd = 1'b0;
        wr = 1'b0;
        mready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic mem_op(input string tag, input logic exp_wr, input logic [27:0] exp_addr,
                          input logic [127:0] exp_wdata, input logic [127:0] line);
        int n = 0;
        while (!(mrd || mwr) && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, {mwr, mrd}, exp_wr ? 2'b10 : 2'b01);
        chk({tag, "_addr"}, maddr, exp_addr);
        if (exp_wr) chk({tag, "_wdata"}, mwdata, exp_wdata);
        mrdata = line;
        mready = 1'b1;
        tick();
        mready = 1'b0;
    endtask

    initial begin
        // reset values while a request is pending
        tick();
        rd = 1'b1;
        addr = 30'h10;
        rst = 1'b1;
        #1;
        chk("rst_stall", stall, 1);
        chk("rst_mem_rw", {mwr, mrd}, 0);
        chk("rst_mem_addr", maddr, 0);
        chk("rst_mem_wdata", mwdata, 0);
        chk("rst_rdata", rdata, 0);
        rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        // cold read miss then zero-wait hits, 2-way
        drive(1, 0, 30'h10, 0);
        chk("cold_stall", stall, 1);
        mem_op("cold", 0, 28'h4, 0, LINE_A);
        chk("cold_hit_stall", stall, 0);
        chk("cold_rdata", rdata, 32'hDEADBEEF);
        chk("cold_mem_idle", {mwr, mrd}, 0);
        tick();
        drive(1, 0, 30'h10, 0);
        chk("hit_stall", stall, 0);
        chk("hit_rdata", rdata, 32'hDEADBEEF);
        tick();
        chk("hit_no_mem", {mwr, mrd}, 0);
        drive(1, 0, 30'h11, 0);
        chk("hit_word1", rdata, 32'h11111111);
        tick();
        drive(1, 0, 30'h13, 0);
        chk("hit_word3", rdata, 32'h33333333);
        tick();
        drive(0, 0, 0, 0);
        mready = 1'b1;
        tick();
        mready = 1'b0;
        chk("stray_ready_mem", {mwr, mrd}, 0);
        drive(1, 0, 30'h10, 0);
        chk("stray_ready_hit", stall, 0);
        tick();
        // write-allocate with read+write high, then dirty eviction
        reset_dut();
        drive(1, 1, 30'h0, 32'hA5A5A5A5);
        chk("wa_stall", stall, 1);
        mem_op("wa", 0, 28'h0, 0, 0);
        chk("wa_hit_stall", stall, 0);
        tick();
        drive(1, 0, 30'h0, 0);
        chk("wa_readback", rdata, 32'hA5A5A5A5);
        tick();
        drive(1, 0, 30'h10, 0);
        mem_op("fill_t1", 0, 28'h4, 0, LINE_A);
        chk("fill_t1_rdata", rdata, 32'hDEADBEEF);
        tick();
        drive(1, 0, 30'h20, 0);
        chk("evict_stall", stall, 1);
        mem_op("evict_wb", 1, 28'h0, 128'hA5A5A5A5, 0);
        mem_op("evict_fill", 0, 28'h8, 0, {96'h0, 32'hB0B0B0B0});
        chk("evict_rdata", rdata, 32'hB0B0B0B0);
        tick();
        drive(1, 0, 30'h10, 0);
        chk("t1_kept", stall, 0);
        tick();
        drive(1, 0, 30'h0, 0);
        chk("t0_gone", stall, 1);
        // LRU order, 4-way, set 1
        sel = 2'd1;
        reset_dut();
        for (int t = 0; t < 4; t++) begin
            drive(1, 0, 30'(t * 16 + 4), 0);
            mem_op($sformatf("lru_fill%0d", t), 0, 28'(t * 4 + 1), 0, {96'h0, 32'hC0DE0000 + 32'(t)});
            chk($sformatf("lru_rdata%0d", t), rdata, 32'hC0DE0000 + 32'(t));
            tick();
        end
        drive(1, 0, 30'h04, 0);
        chk("lru_t0_rehit", stall, 0);
        tick();
        drive(1, 0, 30'h44, 0);
        chk("lru_t4_stall", stall, 1);
        mem_op("lru_t4", 0, 28'h11, 0, {96'h0, 32'hC0DE0004});
        chk("lru_t4_rdata", rdata, 32'hC0DE0004);
        tick();
        drive(1, 0, 30'h04, 0);
        chk("lru_t0_kept", stall, 0);
        chk("lru_t0_rdata", rdata, 32'hC0DE0000);
        tick();
        drive(1, 0, 30'h24, 0);
        chk("lru_t2_kept", stall, 0);
        tick();
        drive(1, 0, 30'h34, 0);
        chk("lru_t3_kept", stall, 0);
        tick();
        drive(1, 0, 30'h14, 0);
        chk("lru_t1_evicted", stall, 1);
        tick();
        chk("lru_t1_fetch", {mwr, mrd}, 2'b01);
        chk("lru_t1_addr", maddr, 28'h5);
        // asynchronous reset in the middle of ALLOCATE
        rst = 1'b1;
        #1;
        chk("rst_alloc_mem_read", mrd, 0);
        chk("rst_alloc_stall", stall, 1);
        rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        drive(1, 0, 30'h04, 0);
        chk("post_rst_miss", stall, 1);
        tick();
        chk("post_rst_fetch", {mwr, mrd}, 2'b01);
        chk("post_rst_addr", maddr, 28'h1);
        // read-only build: writes ignored, never stall, never written back
        sel = 2'd2;
        reset_dut();
        drive(0, 1, 30'h0, 32'h12345678);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("ro_wr_stall%0d", c), stall, 0);
            chk($sformatf("ro_wr_mem%0d", c), {mwr, mrd}, 0);
            tick();
        end
        drive(1, 0, 30'h0, 0);
        chk("ro_rd_stall", stall, 1);
        mem_op("ro_fill", 0, 28'h0, 0, {96'h0, 32'hCAFEF00D});
        chk("ro_rdata", rdata, 32'hCAFEF00D);
        tick();
        drive(1, 1, 30'h0, 32'h12345678);
        chk("ro_wr_hit_stall", stall, 0);
        tick();
        drive(1, 0, 30'h0, 0);
        chk("ro_rdata_kept", rdata, 32'hCAFEF00D);
        tick();
        drive(1, 0, 30'h10, 0);
        mem_op("ro_fill_t1", 0, 28'h4, 0, LINE_A);
        tick();
        drive(1, 0, 30'h20, 0);
        mem_op("ro_no_wb", 0, 28'h8, 0, 0);
        chk("ro_t2_rdata", rdata, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "timeout");
    end
endmodule
